// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI responder constants, FSM states and command-word layout.
package spi_pkg;
  localparam int SPI_WIDTH = 16;
  localparam int SPI_SYNC_STAGES = 2;
  typedef enum logic {IDLE, ACTIVE} spi_state_t;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] payload;
  } spi_cmd_t;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop input synchronizer with level, rise and fall outputs.
module spi_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic hist;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      chain <= {STAGES{INIT}};
      hist <= INIT;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      hist <= chain[STAGES-1];
    end
  assign level = chain[STAGES-1];
  assign rise = level & ~hist;
  assign fall = ~level & hist;
endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder in the clk domain; define SPI_ECHO_EN to echo the previous rx word.
module spi_responder
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             sdi,
  input  logic             cs_n,
  output logic             sdo,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_load,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] OVER = CW'(WIDTH + 1);
  spi_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] tx_sr, tx_word, rx_word;
  logic [WIDTH-2:0] rx_sr;
  logic sck_rise, sck_fall, sdi_s, cs_rise, cs_fall;
  logic [3:0] unused_sync;
  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (
    .clk(clk), .reset(reset), .d(sck), .level(unused_sync[0]), .rise(sck_rise), .fall(sck_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sdi (
    .clk(clk), .reset(reset), .d(sdi), .level(sdi_s), .rise(unused_sync[1]), .fall(unused_sync[2]));
  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(cs_n), .level(unused_sync[3]), .rise(cs_rise), .fall(cs_fall));
`ifdef SPI_ECHO_EN
  logic unused_tx;
  assign unused_tx = ^tx_data;
  assign tx_word = rx_data;
`else
  assign tx_word = tx_data;
`endif
  assign rx_word = {rx_sr, sdi_s};
  always_comb begin
    state_n = state;
    tx_load = 1'b0;
    frame_err = 1'b0;
    if (state == IDLE && cs_fall) begin
      state_n = ACTIVE;
      tx_load = 1'b1;
    end else if (state == ACTIVE && cs_rise) begin
      state_n = IDLE;
      frame_err = (cnt != '0) && (cnt != FULL);
    end
  end
  // cs_n rise takes priority over any sck edge seen in the same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      sdo <= 1'b0;
    end else begin
      state <= state_n;
      rx_valid <= 1'b0;
      if (tx_load) begin
        tx_sr <= tx_word;
        sdo <= tx_word[WIDTH-1];
        cnt <= '0;
      end else if (state == ACTIVE && cs_rise) begin
        sdo <= 1'b0;
      end else if (state == ACTIVE) begin
        if (sck_rise) begin
          rx_sr <= rx_word[WIDTH-2:0];
          cnt <= (cnt == OVER) ? cnt : cnt + 1'b1;
          if (cnt == LAST) begin
            rx_data <= rx_word;
            rx_valid <= 1'b1;
          end
        end
        if (sck_fall) begin
          tx_sr <= tx_sr << 1;
          sdo <= (cnt < FULL) ? tx_sr[WIDTH-2] : 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed SPI frames with hand-computed expectations; also covers SPI_ECHO_EN builds.
module tb_spi_responder;
`ifdef SPI_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, sck = 1'b0, sdi = 1'b0, cs_n = 1'b1;
  logic sdo, tx_load, rx_valid, frame_err;
  logic [15:0] tx_data = '0, rx_data;
  int checks = 0, failures = 0;
  int n_valid = 0, n_load = 0, n_err = 0;
  logic [15:0] last_rx = '0, model_rx = '0;

  spi_responder dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n), .sdo(sdo),
    .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_rx = rx_data;
    end
    if (tx_load) n_load++;
    if (frame_err) n_err++;
  end

  task automatic xfer(input logic [31:0] data, input int nbits, output logic [31:0] got);
    got = '0;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = data[i];
      repeat (4) @(negedge clk);
      got[i] = sdo;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (sdo !== 1'b0) begin failures++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
    checks++; if (tx_load !== 1'b0) begin failures++; $display("FAIL reset_tx_load got=%b exp=0", tx_load); end
    checks++; if (rx_data !== 16'h0) begin failures++; $display("FAIL reset_rx_data got=%h exp=0000", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_normal;
    logic [31:0] got;
    logic [15:0] exp;
    int v0, l0, e0;
    tx_data = 16'hA5C3;
    exp = ECHO ? model_rx : 16'hA5C3;
    v0 = n_valid; l0 = n_load; e0 = n_err;
    xfer(32'h1234, 16, got);
    model_rx = 16'h1234;
    checks++; if (got[15:0] !== exp) begin failures++; $display("FAIL normal_sdo got=%h exp=%h", got[15:0], exp); end
    checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL normal_valid_count got=%0d exp=1", n_valid - v0); end
    checks++; if (last_rx !== 16'h1234) begin failures++; $display("FAIL normal_valid_data got=%h exp=1234", last_rx); end
    checks++; if (rx_data !== 16'h1234) begin failures++; $display("FAIL normal_rx_data got=%h exp=1234", rx_data); end
    checks++; if (n_load - l0 != 1) begin failures++; $display("FAIL normal_tx_load got=%0d exp=1", n_load - l0); end
    checks++; if (n_err - e0 != 0) begin failures++; $display("FAIL normal_frame_err got=%0d exp=0", n_err - e0); end
    checks++; if (sdo !== 1'b0) begin failures++; $display("FAIL normal_sdo_idle got=%b exp=0", sdo); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    logic [15:0] exp;
    int v0, l0;
    v0 = n_valid; l0 = n_load;
    exp = ECHO ? model_rx : tx_data;
    xfer(32'hFFFF, 16, got);
    model_rx = 16'hFFFF;
    checks++; if (got[15:0] !== exp) begin failures++; $display("FAIL b2b_sdo1 got=%h exp=%h", got[15:0], exp); end
    checks++; if (last_rx !== 16'hFFFF) begin failures++; $display("FAIL b2b_data1 got=%h exp=ffff", last_rx); end
    exp = ECHO ? model_rx : tx_data;
    xfer(32'h0001, 16, got);
    model_rx = 16'h0001;
    checks++; if (got[15:0] !== exp) begin failures++; $display("FAIL b2b_sdo2 got=%h exp=%h", got[15:0], exp); end
    checks++; if (last_rx !== 16'h0001) begin failures++; $display("FAIL b2b_data2 got=%h exp=0001", last_rx); end
    checks++; if (n_valid - v0 != 2) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=2", n_valid - v0); end
    checks++; if (n_load - l0 != 2) begin failures++; $display("FAIL b2b_tx_load got=%0d exp=2", n_load - l0); end
  endtask

  task automatic test_short_frame;
    logic [31:0] got;
    logic [15:0] exp;
    int v0, e0;
    tx_data = 16'h3C3C;
    exp = ECHO ? model_rx : 16'h3C3C;
    v0 = n_valid; e0 = n_err;
    xfer(32'h55, 7, got);
    checks++; if (got[6:0] !== exp[15:9]) begin failures++; $display("FAIL short_sdo got=%h exp=%h", got[6:0], exp[15:9]); end
    checks++; if (n_err - e0 != 1) begin failures++; $display("FAIL short_frame_err got=%0d exp=1", n_err - e0); end
    checks++; if (n_valid - v0 != 0) begin failures++; $display("FAIL short_valid got=%0d exp=0", n_valid - v0); end
    checks++; if (rx_data !== 16'h0001) begin failures++; $display("FAIL short_rx_hold got=%h exp=0001", rx_data); end
    checks++; if (sdo !== 1'b0) begin failures++; $display("FAIL short_sdo_idle got=%b exp=0", sdo); end
  endtask

  task automatic test_overrun;
    logic [31:0] got;
    logic [15:0] exp;
    int v0, e0;
    tx_data = 16'hC0DE;
    exp = ECHO ? model_rx : 16'hC0DE;
    v0 = n_valid; e0 = n_err;
    xfer(32'hBEEFA, 20, got);
    model_rx = 16'hBEEF;
    checks++; if (got[19:4] !== exp) begin failures++; $display("FAIL overrun_sdo got=%h exp=%h", got[19:4], exp); end
    checks++; if (got[3:0] !== 4'h0) begin failures++; $display("FAIL overrun_sdo_tail got=%h exp=0", got[3:0]); end
    checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL overrun_valid got=%0d exp=1", n_valid - v0); end
    checks++; if (last_rx !== 16'hBEEF) begin failures++; $display("FAIL overrun_valid_data got=%h exp=beef", last_rx); end
    checks++; if (rx_data !== 16'hBEEF) begin failures++; $display("FAIL overrun_rx_data got=%h exp=beef", rx_data); end
    checks++; if (n_err - e0 != 1) begin failures++; $display("FAIL overrun_frame_err got=%0d exp=1", n_err - e0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] got;
    logic [15:0] exp;
    int v0;
    tx_data = 16'hFFFF;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      sdi = i[0];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({sdo, tx_load, rx_valid, frame_err} !== 4'b0) begin failures++; $display("FAIL midreset_flags got=%b exp=0000", {sdo, tx_load, rx_valid, frame_err}); end
    checks++; if (rx_data !== 16'h0) begin failures++; $display("FAIL midreset_rx_data got=%h exp=0000", rx_data); end
    model_rx = 16'h0;
    cs_n = 1'b1;
    sdi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    v0 = n_valid;
    exp = ECHO ? model_rx : 16'hFFFF;
    xfer(32'h00FF, 16, got);
    model_rx = 16'h00FF;
    checks++; if (got[15:0] !== exp) begin failures++; $display("FAIL midreset_sdo got=%h exp=%h", got[15:0], exp); end
    checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL midreset_valid got=%0d exp=1", n_valid - v0); end
    checks++; if (rx_data !== 16'h00FF) begin failures++; $display("FAIL midreset_rx_data2 got=%h exp=00ff", rx_data); end
  endtask

`ifdef SPI_ECHO_EN
  task automatic test_echo;
    logic [31:0] got;
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tx_data = 16'h9999;
    xfer(32'h5A5A, 16, got);
    checks++; if (got[15:0] !== 16'h0000) begin failures++; $display("FAIL echo_first got=%h exp=0000", got[15:0]); end
    xfer(32'h0000, 16, got);
    checks++; if (got[15:0] !== 16'h5A5A) begin failures++; $display("FAIL echo_second got=%h exp=5a5a", got[15:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_back_to_back();
    test_short_frame();
    test_overrun();
    test_reset_mid_frame();
`ifdef SPI_ECHO_EN
    test_echo();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
